// File: rtl/compare_seq.sv
// compare_seq: serial MSB-first A/B magnitude comparator (Start/Ready/Busy/Done handshake, cascade inputs, registered QAGB/QASB/QAEB)
module compare_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             Signed,
  input  logic             CasGT,
  input  logic             CasLT,
  input  logic             CasEQ,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic             QAGB,
  output logic             QASB,
  output logic             QAEB
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic cgt, clt, ceq;
  logic [SLICE-1:0] sa, sb;
  logic [2:0] cas_res;
  assign sa = a_q[idx*SLICE +: SLICE];
  assign sb = b_q[idx*SLICE +: SLICE];
  assign cas_res = ceq ? 3'b001 : cgt ? 3'b100 : clt ? 3'b010 : 3'b001;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      Ready <= 1'b1;
      Busy <= 1'b0;
      Done <= 1'b0;
      {QAGB, QASB, QAEB} <= 3'b000;
    end else begin
      case (state)
        IDLE: if (Start) begin
          a_q <= DataA ^ (Signed ? MSB : '0);
          b_q <= DataB ^ (Signed ? MSB : '0);
          {cgt, clt, ceq} <= {CasGT, CasLT, CasEQ};
          idx <= IW'(NSLICE - 1);
          state <= RUN;
          Ready <= 1'b0;
          Busy <= 1'b1;
        end
        RUN: if (sa != sb || idx == '0) begin
          {QAGB, QASB, QAEB} <= sa != sb ? {sa > sb, sa < sb, 1'b0} : cas_res;
          state <= DONE;
          Busy <= 1'b0;
          Done <= 1'b1;
        end else begin
          idx <= idx - 1'b1;
        end
        DONE: begin
          state <= IDLE;
          Done <= 1'b0;
          Ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b1;
          Busy <= 1'b0;
          Done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_compare_seq.sv
// tb_compare_seq: directed bench for compare_seq (8-bit and 16-bit instances) with a cycle-level reference model
module tb_compare_seq;
  logic CLK = 0, RST = 1;
  logic [1:0] st = '0;
  logic [15:0] a = '0, b = '0;
  logic sg = 0, cg = 0, cl = 0, ce = 0;
  wire [5:0] o8, o16;
  int pass = 0, total = 0;
  bit armed = 0;
  int rem [2];
  logic [2:0] res [2], pend [2];
  always #5 CLK = ~CLK;
  compare_seq #(.WIDTH(8), .SLICE(4)) dut8 (
    .CLK(CLK), .RST(RST), .Start(st[0]), .DataA(a[7:0]), .DataB(b[7:0]), .Signed(sg),
    .CasGT(cg), .CasLT(cl), .CasEQ(ce), .Ready(o8[5]), .Busy(o8[4]), .Done(o8[3]),
    .QAGB(o8[2]), .QASB(o8[1]), .QAEB(o8[0]));
  compare_seq #(.WIDTH(16), .SLICE(4)) dut16 (
    .CLK(CLK), .RST(RST), .Start(st[1]), .DataA(a), .DataB(b), .Signed(sg),
    .CasGT(cg), .CasLT(cl), .CasEQ(ce), .Ready(o16[5]), .Busy(o16[4]), .Done(o16[3]),
    .QAGB(o16[2]), .QASB(o16[1]), .QAEB(o16[0]));
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic void ref_cmp(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                  input logic s, input logic g, input logic l, input logic e,
                                  output logic [2:0] r, output int k);
    longint va, vb, m;
    m = (longint'(1) << w) - 1;
    va = longint'(ia) & m;
    vb = longint'(ib) & m;
    if (s && va[w-1]) va = va - (m + 1);
    if (s && vb[w-1]) vb = vb - (m + 1);
    r = va > vb ? 3'b100 : va < vb ? 3'b010 : e ? 3'b001 : g ? 3'b100 : l ? 3'b010 : 3'b001;
    k = w / 4;
    for (int i = 0; i < w / 4; i++)
      if ((((ia ^ ib) >> (4 * i)) & 16'hF) != 0) k = w / 4 - i;
  endfunction
  always @(posedge CLK) begin
    logic [2:0] r;
    int k;
    for (int d = 0; d < 2; d++) begin
      if (RST) begin
        rem[d] <= 0;
        res[d] <= '0;
      end else if (rem[d] == 0) begin
        if (st[d]) begin
          ref_cmp(d ? 16 : 8, a, b, sg, cg, cl, ce, r, k);
          pend[d] <= r;
          rem[d] <= k + 1;
        end
      end else begin
        rem[d] <= rem[d] - 1;
        if (rem[d] == 2) res[d] <= pend[d];
      end
    end
  end
  always @(negedge CLK) if (armed) begin
    chk("cycle dut8", int'(o8), int'({rem[0] == 0, rem[0] > 1, rem[0] == 1, res[0]}));
    chk("cycle dut16", int'(o16), int'({rem[1] == 0, rem[1] > 1, rem[1] == 1, res[1]}));
  end
  task automatic run(input int d, input logic [15:0] ia, input logic [15:0] ib, input logic s,
                     input logic g, input logic l, input logic e, input logic [2:0] er,
                     input int elat, input string nm, input bit poke, input logic [2:0] hold,
                     input bit pre);
    int c;
    logic [5:0] o;
    if (pre) @(negedge CLK);
    a = ia; b = ib; sg = s; cg = g; cl = l; ce = e; st[d] = 1;
    @(negedge CLK);
    st[d] = 0; a = ~ia; b = ib ^ 16'h5a5a; sg = ~s; cg = ~g; cl = ~l; ce = ~e;
    c = 1;
    o = d ? o16 : o8;
    while (!o[3] && c < 40) begin
      if (poke && c == 2) begin
        chk({nm, " hold"}, int'(o[2:0]), int'(hold));
        st[d] = 1;
      end else st[d] = 0;
      @(negedge CLK);
      c++;
      o = d ? o16 : o8;
    end
    st[d] = 0;
    chk({nm, " latency"}, c, elat);
    chk({nm, " result"}, int'(o[2:0]), int'(er));
    if (poke) begin
      st[d] = 1;
      @(negedge CLK);
      st[d] = 0;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge CLK);
    armed = 1;
    chk("reset dut8", int'(o8), 'h20);
    chk("reset dut16", int'(o16), 'h20);
    RST = 0;
    run(0, 16'h95, 16'h3C, 0, 0, 0, 0, 3'b100, 2, "ugt", 0, 0, 1);
    run(0, 16'h37, 16'h39, 0, 0, 0, 0, 3'b010, 3, "ult", 0, 0, 1);
    run(0, 16'hA5, 16'hA5, 0, 1, 0, 0, 3'b100, 3, "casgt", 0, 0, 1);
    run(0, 16'hA5, 16'hA5, 0, 1, 1, 1, 3'b001, 3, "caseq", 0, 0, 1);
    run(0, 16'hA5, 16'hA5, 0, 0, 1, 0, 3'b010, 3, "caslt", 0, 0, 1);
    run(0, 16'hA5, 16'hA5, 0, 0, 0, 0, 3'b001, 3, "casnone", 0, 0, 1);
    run(0, 16'h80, 16'h01, 1, 0, 0, 0, 3'b010, 2, "sgn_lt", 0, 0, 1);
    run(0, 16'h80, 16'h01, 0, 0, 0, 0, 3'b100, 2, "uns_gt", 0, 0, 1);
    run(1, 16'h8000, 16'h0001, 0, 0, 0, 0, 3'b100, 2, "w16_gt", 0, 0, 1);
    run(1, 16'h1234, 16'h1235, 0, 0, 0, 0, 3'b010, 5, "w16_lt", 1, 3'b100, 1);
    @(negedge CLK);
    a = 16'h1234; b = 16'h1235; sg = 0; cg = 0; cl = 0; ce = 0; st[1] = 1;
    @(negedge CLK);
    st[1] = 0;
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    chk("rst_abort", int'(o16), 'h20);
    RST = 0;
    run(1, 16'h00F0, 16'h0F00, 0, 0, 0, 0, 3'b010, 3, "post_rst", 0, 0, 0);
    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/compare_seq.md
COMPARE_SEQ -- requirements
Module: compare_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be a multiple of SLICE and at least SLICE.
REQ-002 Parameter SLICE, default 4, bits compared per cycle; NSLICE = WIDTH/SLICE.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  rising-edge clock for all state.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 Start  in  1  request; accepted only when Ready=1.
REQ-007 DataA  in  WIDTH  operand A; sampled on accepted Start.
REQ-008 DataB  in  WIDTH  operand B; sampled on accepted Start.
REQ-009 Signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled on accepted Start.
REQ-010 CasGT, CasLT, CasEQ  in  1 each  cascade inputs from a lower-order stage; sampled on accepted Start.
REQ-011 Ready  out  1  high in IDLE only.
REQ-012 Busy  out  1  high in RUN only.
REQ-013 Done  out  1  one-cycle pulse; result valid.
REQ-014 QAGB, QASB, QAEB  out  1 each  registered A>B, A<B, A=B results.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE with Start=1: capture DataA, DataB, Signed and Cas*; set slice index to NSLICE-1; go to RUN.
REQ-017 IDLE with Start=0: stay in IDLE.
REQ-018 Start in RUN or DONE SHALL be ignored; captured operands SHALL NOT change.
REQ-019 RUN, one slice per cycle, MSB slice first: compare captured A[idx] with B[idx] as unsigned SLICE-bit values.
REQ-020 RUN, Signed=1: invert bit WIDTH-1 of both operands before comparing the MSB slice.
REQ-021 RUN, slice differs: register QAGB/QASB from the slice result; go to DONE (early termination).
REQ-022 RUN, slice equal and idx>0: decrement idx; stay in RUN.
REQ-023 RUN, slice equal and idx=0: resolve from the cascade inputs, then go to DONE.
- Priority: CasEQ=1 -> QAEB.
- Otherwise CasGT=1 -> QAGB.
- Otherwise CasLT=1 -> QASB.
- Otherwise -> QAEB.
REQ-024 Every result write SHALL leave exactly one of QAGB/QASB/QAEB high.
REQ-025 DONE: Done=1 for exactly one cycle, then go to IDLE; Start in that cycle is ignored.
REQ-026 Result outputs SHALL hold their value until the next result write; no change while RUN is in progress.
REQ-027 Latency: accepted Start at edge 0 -> Done high in cycle k+1, where k = number of slices examined (1..NSLICE).
REQ-028 Best case is 2 cycles; worst case is NSLICE+1 cycles.
REQ-029 Changes on DataA/DataB/Signed/Cas* after acceptance SHALL NOT affect the result in progress.
REQ-030 Only the slice index counter (clog2(NSLICE) bits, min 1) SHALL wrap-protect: it never decrements below 0.

Reset
REQ-031 RST=1 at a rising edge: state IDLE, index 0, and all outputs low (Done, Busy, QAGB, QASB, QAEB), except Ready, which SHALL be 1 after reset.
REQ-032 RST SHALL take priority over Start and over any in-progress RUN; the partial compare SHALL be discarded with no Done pulse.
REQ-033 The first Start after reset release SHALL be accepted if asserted in the first cycle with RST=0.

Verification
REQ-034 WIDTH=8, unsigned: A=0x95, B=0x3C -> MSB slice 9>3; Done in cycle 2; QAGB=1, QASB=0, QAEB=0.
REQ-035 WIDTH=8, unsigned: A=0x37, B=0x39 -> slice 3=3, then 7<9; Done in cycle 3; QASB=1.
REQ-036 WIDTH=8: A=B=0xA5 with cascade inputs:
- CasEQ=0, CasGT=1 -> QAGB=1, Done in cycle 3.
- CasEQ=1 -> QAEB=1.
- All cascade inputs 0 -> QAEB=1.
REQ-037 WIDTH=8, Signed=1: A=0x80 (-128), B=0x01 -> QASB=1. Same operands with Signed=0 -> QAGB=1.
REQ-038 WIDTH=16: A=0x1234, B=0x1235 -> Done in cycle 5 with QASB=1.
- Start pulsed during RUN is ignored.
- Outputs hold the prior result until Done.
REQ-039 RST asserted in the 2nd RUN cycle of a WIDTH=16 compare:
- No Done pulse; outputs return to 0; Ready=1 on the next cycle.
- A new Start is then accepted and completes normally.
